// File: rtl/spi_tx_packet_scheduler_pkg.sv
// Shared types, sizing helpers and default widths for the SPI transmit packet scheduler.
package spi_tx_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // A single-chunk packet still needs a one-bit counter to keep the datapath well formed.
  function automatic int cnt_width(input int n_chunks);
    return (n_chunks > 1) ? $clog2(n_chunks) : 1;
  endfunction

  localparam int def_nreqs      = 4;
  localparam int def_nbits_in   = 32;
  localparam int def_nbits_out  = 8;
  localparam int def_num_chunks = ceil_div(def_nbits_in, def_nbits_out);
  localparam int cnt_bits       = cnt_width(def_num_chunks);
  localparam int src_bits       = $clog2(def_nreqs);

endpackage

// File: rtl/spi_tx_packet_scheduler_if.sv
// Requester-side and chunk-side handshake bundle of the scheduler.
interface spi_tx_packet_scheduler_if #(
  parameter int nreqs     = spi_tx_sched_pkg::def_nreqs,
  parameter int nbits_in  = spi_tx_sched_pkg::def_nbits_in,
  parameter int nbits_out = spi_tx_sched_pkg::def_nbits_out,
  parameter int src_bits  = $clog2(nreqs)
);
  logic [nreqs-1:0]          req_val;
  logic [nreqs-1:0]          req_rdy;
  logic [nreqs*nbits_in-1:0] req_msg;
  logic                      resp_val;
  logic                      resp_rdy;
  logic [nbits_out-1:0]      resp_msg;
  logic [src_bits-1:0]       resp_src;
  logic                      resp_last;

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg, resp_src, resp_last
  );

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg, resp_src, resp_last
  );
endinterface

// File: rtl/spi_tx_packet_scheduler_arbiter.sv
// Round-robin arbiter: combinational grant from the valid vector and a priority
// pointer that advances past the winner only when the grant is taken.
module spi_rr_arbiter #(
  parameter int nreqs    = 4,
  parameter int src_bits = $clog2(nreqs)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [nreqs-1:0]    val,
  input  logic                en,
  output logic [nreqs-1:0]    grant,
  output logic [src_bits-1:0] grant_idx
);
  logic [src_bits-1:0]  ptr;
  logic [2*nreqs-1:0]   val_rot;
  int                   sum;

  // Bit k of val_rot is requester (ptr + k) mod nreqs.
  assign val_rot = {val, val} >> ptr;

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant_idx = '0;
    sum       = 0;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int k = nreqs - 1; k >= 0; k--) begin
      if (val_rot[k]) begin
        sum = int'(ptr) + k;
        if (sum >= nreqs) sum = sum - nreqs;
        grant_idx = src_bits'(sum);
      end
    end
    grant = '0;
    if (|val) grant[grant_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (grant_idx == src_bits'(nreqs - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spi_tx_packet_scheduler.sv
// Shares one narrow SPI transmit chunk stream among wide-packet requesters,
// emitting each granted packet most-significant chunk first.
module spi_tx_packet_scheduler
  import spi_tx_sched_pkg::*;
#(
  parameter int nreqs     = def_nreqs,
  parameter int nbits_in  = def_nbits_in,
  parameter int nbits_out = def_nbits_out
) (
  input  logic                      clk,
  input  logic                      reset,
  spi_tx_packet_scheduler_if.slave  bus,
  output logic                      busy
);
  localparam int n_chunks = ceil_div(nbits_in, nbits_out);
  localparam int cnt_w    = cnt_width(n_chunks);
  localparam int src_w    = $clog2(nreqs);
  localparam int pad_w    = n_chunks * nbits_out;

  state_t               state, state_nxt;
  logic [cnt_w-1:0]     cnt, cnt_nxt, sel;
  logic [nbits_in-1:0]  data_r;
  logic [src_w-1:0]     src_r;
  logic [nreqs-1:0]     grant;
  logic [src_w-1:0]     grant_idx;
  logic                 accept, fire, last, sending;
  logic [pad_w-1:0]     data_pad;
  logic [nbits_out-1:0] chunk;

  spi_rr_arbiter #(
    .nreqs    (nreqs),
    .src_bits (src_w)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .val       (bus.req_val),
    .en        (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Any valid requester in IDLE is granted, so acceptance needs no further qualification.
  assign accept  = (state == IDLE) && (|bus.req_val);
  assign fire    = (state == SEND) && bus.resp_rdy;
  assign last    = (cnt == cnt_w'(n_chunks - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
          cnt_nxt   = '0;
        end
      end
      SEND: begin
        if (fire) begin
          if (last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      data_r <= '0;
      src_r  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        data_r <= bus.req_msg[grant_idx*nbits_in +: nbits_in];
        src_r  <= grant_idx;
      end
    end
  end

  // Zero-extend so a partial top chunk reads as leading zeros.
  assign data_pad = pad_w'(data_r);
  assign sel      = cnt_w'(n_chunks - 1) - cnt;
  assign chunk    = data_pad[sel*nbits_out +: nbits_out];

  // Outputs are forced quiet while reset is held, before the registers have cleared.
  assign sending       = (state == SEND) && !reset;
  assign busy          = sending;
  assign bus.resp_val  = sending;
  assign bus.resp_last = sending && last;
  assign bus.resp_msg  = reset ? '0 : chunk;
  assign bus.resp_src  = reset ? '0 : src_r;
  assign bus.req_rdy   = ((state == IDLE) && !reset) ? grant : '0;

endmodule

// File: tb/tb_spi_tx_packet_scheduler.sv
// Directed bench for the scheduler: a round-robin reference model feeds a chunk
// scoreboard for the 32/8 build; 20/8 and single-chunk builds cover width corners.
module tb_spi_tx_packet_scheduler;

  typedef struct packed {
    logic [7:0] msg;
    logic [1:0] src;
    logic       last;
  } chunk_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_tx_packet_scheduler_if #(.nreqs(4), .nbits_in(32), .nbits_out(8)) a_if ();
  spi_tx_packet_scheduler_if #(.nreqs(4), .nbits_in(20), .nbits_out(8)) b_if ();
  spi_tx_packet_scheduler_if #(.nreqs(2), .nbits_in(8),  .nbits_out(8)) c_if ();
  logic a_busy, b_busy, c_busy;

  spi_tx_packet_scheduler #(.nreqs(4), .nbits_in(32), .nbits_out(8)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave), .busy(a_busy));
  spi_tx_packet_scheduler #(.nreqs(4), .nbits_in(20), .nbits_out(8)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave), .busy(b_busy));
  spi_tx_packet_scheduler #(.nreqs(2), .nbits_in(8), .nbits_out(8)) dut_c (
    .clk(clk), .reset(reset), .bus(c_if.slave), .busy(c_busy));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state for instance A.
  logic [3:0]  pend;
  logic [31:0] pmsg [4];
  logic        rdy_a;
  logic        reload;
  logic        m_send;
  int          m_ptr;
  int          seq;
  chunk_t      exp_q [$];
  int          grant_log [$];

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic drive_a();
    a_if.req_val  = pend;
    a_if.resp_rdy = rdy_a;
    for (int i = 0; i < 4; i++) a_if.req_msg[i*32 +: 32] = pmsg[i];
  endtask

  // One clock of instance A: drive on the falling edge, compare 1 ns later.
  task automatic cycle_a();
    int       g;
    logic [3:0] exp_rdy;
    chunk_t   c;
    @(negedge clk);
    drive_a();
    #1;
    if (reset) begin
      check("rst_req_rdy",   32'(a_if.req_rdy),   32'd0);
      check("rst_resp_val",  32'(a_if.resp_val),  32'd0);
      check("rst_busy",      32'(a_busy),         32'd0);
      check("rst_resp_last", 32'(a_if.resp_last), 32'd0);
      check("rst_resp_msg",  32'(a_if.resp_msg),  32'd0);
      check("rst_resp_src",  32'(a_if.resp_src),  32'd0);
      m_send = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
      return;
    end
    g       = m_send ? -1 : rr_pick(pend, m_ptr);
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    check("req_rdy",  32'(a_if.req_rdy),  32'(exp_rdy));
    check("busy",     32'(a_busy),        32'(m_send));
    check("resp_val", 32'(a_if.resp_val), 32'(m_send));
    if (m_send) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        c = exp_q[0];
        check("resp_msg",  32'(a_if.resp_msg),  32'(c.msg));
        check("resp_src",  32'(a_if.resp_src),  32'(c.src));
        check("resp_last", 32'(a_if.resp_last), 32'(c.last));
        if (rdy_a) begin
          void'(exp_q.pop_front());
          if (c.last) m_send = 1'b0;
        end
      end
    end else if (g >= 0) begin
      for (int k = 0; k < 4; k++)
        exp_q.push_back('{msg: pmsg[g][31-8*k -: 8], src: 2'(g), last: (k == 3)});
      grant_log.push_back(g);
      m_ptr  = (g + 1) % 4;
      m_send = 1'b1;
      if (reload) begin
        seq++;
        pmsg[g] = {8'(g), 8'(seq), 16'hC0DE};
      end else begin
        pend[g] = 1'b0;
      end
    end
  endtask

  task automatic check_grants(input string tag, input int exp_list [$]);
    check({tag, "_count"}, 32'(grant_log.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < grant_log.size(); i++)
      check(tag, 32'(grant_log[i]), 32'(exp_list[i]));
    grant_log.delete();
  endtask

  chunk_t     bq [$];
  chunk_t     c_exp;
  logic [1:0] c_acc;

  initial begin
    reset  = 1'b1;
    pend   = '0;
    rdy_a  = 1'b1;
    reload = 1'b0;
    m_send = 1'b0;
    m_ptr  = 0;
    seq    = 0;
    for (int i = 0; i < 4; i++) pmsg[i] = '0;
    b_if.req_val = '0; b_if.req_msg = '0; b_if.resp_rdy = 1'b1;
    c_if.req_val = '0; c_if.req_msg = '0; c_if.resp_rdy = 1'b1;

    // Reset cycles, with a requester already valid to show nothing is granted.
    pend = 4'b0001;
    pmsg[0] = 32'hABCD_1234;
    repeat (2) cycle_a();
    check("rst_b_busy", 32'(b_busy), 32'd0);
    check("rst_c_rdy",  32'(c_if.req_rdy), 32'd0);
    reset = 1'b0;

    // Single packet 0xABCD1234 from requester 0, then idle.
    repeat (6) cycle_a();
    check("single_drain", 32'(exp_q.size()), 32'd0);
    check_grants("single_grant", '{0});

    // Simultaneous req0/req2 straight out of reset.
    reset = 1'b1; cycle_a(); reset = 1'b0;
    pend = 4'b0101; pmsg[0] = 32'h0102_0304; pmsg[2] = 32'hA0B0_C0D0;
    repeat (11) cycle_a();
    check_grants("pair_order", '{0, 2});
    // Pointer must now sit at 3: with 0, 1 and 3 valid, 3 wins.
    pend = 4'b1011; pmsg[1] = 32'h1111_0000; pmsg[3] = 32'h3333_0000;
    cycle_a();
    pend = '0;
    repeat (5) cycle_a();
    check_grants("ptr_after_pair", '{3});

    // Backpressure on the second chunk with another requester waiting.
    reset = 1'b1; cycle_a(); reset = 1'b0;
    pend = 4'b0001; pmsg[0] = 32'hABCD_1234;
    repeat (2) cycle_a();
    rdy_a = 1'b0;
    pend  = 4'b0010; pmsg[1] = 32'h5566_7788;
    repeat (3) cycle_a();
    rdy_a = 1'b1;
    repeat (9) cycle_a();
    check("bp_drain", 32'(exp_q.size()), 32'd0);
    check_grants("bp_order", '{0, 1});

    // All four held valid continuously from pointer 0.
    reset = 1'b1; cycle_a(); reset = 1'b0;
    reload = 1'b1;
    pend = 4'b1111;
    for (int i = 0; i < 4; i++) pmsg[i] = {8'(i), 8'hFF, 16'h1234};
    repeat (25) cycle_a();
    pend = '0; reload = 1'b0;
    cycle_a();
    check("rr_drain", 32'(exp_q.size()), 32'd0);
    check_grants("rr_order", '{0, 1, 2, 3, 0});

    // Reset during the third chunk of a req2 packet; req1 then wins from ptr 0.
    pend = 4'b0100; pmsg[2] = 32'hDEAD_BEEF;
    repeat (3) cycle_a();
    reset = 1'b1; cycle_a(); reset = 1'b0;
    pend = '0;
    cycle_a();
    pend = 4'b1010; pmsg[1] = 32'h1122_3344; pmsg[3] = 32'h9988_7766;
    repeat (11) cycle_a();
    check("rst_mid_drain", 32'(exp_q.size()), 32'd0);
    check_grants("rst_mid_order", '{2, 1, 3});

    // Withdrawal before any handshake leaves the scheduler idle and ptr untouched.
    @(negedge clk);
    a_if.req_val = 4'b1000;
    #1 check("wd_rdy_raised", 32'(a_if.req_rdy), 32'h8);
    a_if.req_val = 4'b0000;
    #1 check("wd_rdy_dropped", 32'(a_if.req_rdy), 32'h0);
    pend = '0;
    repeat (3) cycle_a();
    pend = 4'b1111;
    for (int i = 0; i < 4; i++) pmsg[i] = {8'hE0 | 8'(i), 24'h00_0A0B};
    cycle_a();
    pend = '0;
    repeat (5) cycle_a();
    check_grants("wd_ptr_kept", '{0});

    // 20-bit packet on 8-bit chunks: zero-extended top chunk.
    @(negedge clk);
    b_if.req_val = 4'b0010;
    b_if.req_msg[20 +: 20] = 20'hABCDE;
    bq.push_back('{msg: 8'h0A, src: 2'd1, last: 1'b0});
    bq.push_back('{msg: 8'hBC, src: 2'd1, last: 1'b0});
    bq.push_back('{msg: 8'hDE, src: 2'd1, last: 1'b1});
    #1 check("b_req_rdy", 32'(b_if.req_rdy), 32'h2);
    for (int n = 0; n < 10 && bq.size() > 0; n++) begin
      @(negedge clk);
      b_if.req_val = '0;
      #1;
      if (b_if.resp_val) begin
        c_exp = bq.pop_front();
        check("b_resp_msg",  32'(b_if.resp_msg),  32'(c_exp.msg));
        check("b_resp_src",  32'(b_if.resp_src),  32'(c_exp.src));
        check("b_resp_last", 32'(b_if.resp_last), 32'(c_exp.last));
      end
    end
    check("b_drain", 32'(bq.size()), 32'd0);
    @(negedge clk);
    #1 check("b_busy_after", 32'(b_busy), 32'd0);

    // Single-chunk packets: every chunk is last; both requesters served in order.
    c_acc = '0;
    @(negedge clk);
    c_if.req_val = 2'b11;
    c_if.req_msg = {8'hC3, 8'h5A};
    bq.push_back('{msg: 8'h5A, src: 2'd0, last: 1'b1});
    bq.push_back('{msg: 8'hC3, src: 2'd1, last: 1'b1});
    for (int n = 0; n < 12 && bq.size() > 0; n++) begin
      #1;
      c_acc = c_if.req_rdy & c_if.req_val;
      if (c_if.resp_val) begin
        c_exp = bq.pop_front();
        check("c_resp_msg",  32'(c_if.resp_msg),  32'(c_exp.msg));
        check("c_resp_src",  32'(c_if.resp_src),  32'(c_exp.src));
        check("c_resp_last", 32'(c_if.resp_last), 32'(c_exp.last));
      end
      @(negedge clk);
      c_if.req_val = c_if.req_val & ~c_acc;
    end
    check("c_drain", 32'(bq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
